data_memory_sized: RTL

- Successor to the word-only data memory. It supports byte, halfword and word loads and stores with per-byte write enables and load sign/zero extension.
- Read latency is configurable through a response pipeline. Misaligned and out-of-range accesses are reported instead of silently aliased.
- Sits in the MEM stage between the ALU address output and the writeback mux. One request per cycle, in-order responses.

---
 rtl/data_memory_sized.sv | 84 ++++++++
 1 files changed

// File: rtl/data_memory_sized.sv
// data_memory_sized: byte-writable little-endian data memory with sized loads/stores,
// misalignment and range checking, and a registered response READ_LATENCY cycles out.
module data_memory_sized #(
   parameter int DEPTH_WORDS  = 1024,
   parameter int READ_LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   output logic        rsp_valid,
   output logic [31:0] read_data,
   output logic        misaligned_err,
   output logic        range_err
);
   localparam int IW = $clog2(DEPTH_WORDS);
   typedef struct packed {
      logic        v;
      logic        w;
      logic [1:0]  sz;
      logic        u;
      logic [1:0]  off;
      logic        mis;
      logic        rng;
      logic [31:0] word;
   } st_t;
   logic [31:0] mem [DEPTH_WORDS];
   logic [IW-1:0] idx;
   logic mis, rng;
   logic [3:0] be;
   logic [31:0] wd;
   st_t cur, fin;
   logic [7:0] b;
   logic [15:0] h;
   logic [31:0] ext, rd;
   always_comb begin
      idx = addr[IW+1:2];
      mis = req_size == 2'b11 || (req_size == 2'b01 && addr[0]) || (req_size == 2'b10 && addr[1:0] != 2'b00);
      // full upper address compared so out-of-range never aliases onto low words
      rng = {2'b00, addr[31:2]} >= 32'(DEPTH_WORDS);
      be = req_size == 2'b00 ? 4'b0001 << addr[1:0] : req_size == 2'b01 ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
      wd = req_size == 2'b00 ? {4{write_data[7:0]}} : req_size == 2'b01 ? {2{write_data[15:0]}} : write_data;
      cur = '{v: req_valid, w: req_write, sz: req_size, u: req_unsigned, off: addr[1:0], mis: mis, rng: rng, word: mem[idx]};
   end
   always_ff @(posedge clk)
      if (reset_n && req_valid && req_write && !mis && !rng)
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
   if (READ_LATENCY == 1) begin : g_direct
      assign fin = cur;
   end else begin : g_pipe
      st_t pipe [READ_LATENCY-1];
      always_ff @(posedge clk or negedge reset_n)
         if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY-1; i++) pipe[i] <= '0;
         end else begin
            pipe[0] <= cur;
            for (int i = 1; i < READ_LATENCY-1; i++) pipe[i] <= pipe[i-1];
         end
      assign fin = pipe[READ_LATENCY-2];
   end
   always_comb begin
      b = 8'(fin.word >> {fin.off, 3'b000});
      h = fin.off[1] ? fin.word[31:16] : fin.word[15:0];
      ext = fin.sz == 2'b00 ? {{24{~fin.u & b[7]}}, b} : fin.sz == 2'b01 ? {{16{~fin.u & h[15]}}, h} : fin.word;
      rd = (!fin.v || fin.w || fin.mis || fin.rng) ? 32'd0 : ext;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         rsp_valid      <= 1'b0;
         read_data      <= '0;
         misaligned_err <= 1'b0;
         range_err      <= 1'b0;
      end else begin
         rsp_valid      <= fin.v;
         read_data      <= rd;
         misaligned_err <= fin.v & fin.mis;
         range_err      <= fin.v & fin.rng;
      end
endmodule
